instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the instruction memory. It owns the fetch PC, drives the word address into the combinational-read instruction memory, and captures each returned word with its PC into a small FIFO. Decode drains that FIFO through a valid/ready handshake. Execute can redirect fetch on a taken branch or jump, which flushes the FIFO; a misaligned redirect target halts fetch until the next aligned redirect.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 32, PC / address width
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, fetch buffer entries (power of 2, >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
instr_addr  output  ADDR_WIDTH  fetch address to instruction memory; equals fetch PC combinationally
instr  input  DATA_WIDTH  word returned combinationally for instr_addr
redirect_valid  input  1  redirect fetch this cycle
redirect_pc  input  ADDR_WIDTH  redirect target
out_valid  output  1  FIFO head valid
out_ready  input  1  decode accepts head
out_instr  output  DATA_WIDTH  head instruction
out_pc  output  ADDR_WIDTH  head PC
out_pc_plus4  output  ADDR_WIDTH  out_pc + 4 (modulo 2^ADDR_WIDTH)
fetch_err  output  1  high while halted on a misaligned redirect

Behaviour:
- Reset (asynchronous, rst_n=0):
  - fpc=RESET_PC; FIFO empty (count, read and write pointers = 0); state=RUN.
  - out_valid=0, fetch_err=0, instr_addr=RESET_PC.
  - out_instr, out_pc and out_pc_plus4 are don't-care while out_valid=0.
- States:
  - RUN: fetching.
  - HALT: fetch stopped after a misaligned redirect.
- pop = out_valid & out_ready. Head is removed at the clock edge.
- push, in RUN only: fires when redirect_valid=0 and (count<FIFO_DEPTH or pop).
  - Write {fpc, instr} at the write pointer; fpc <= fpc+4.
  - Wrap: 32'hFFFF_FFFC+4 -> 32'h0.
- Simultaneous push and pop when full: allowed; count is unchanged.
- Count update: count_next = count + push - pop (before any flush). Pointers wrap modulo FIFO_DEPTH.
- Redirect (redirect_valid=1) has priority over push and pop at the edge:
  - FIFO flushed: count=0, pointers reset; out_valid=0 next cycle.
  - If redirect_pc[1:0]==0: fpc <= redirect_pc, state <= RUN, fetch_err <= 0.
  - If redirect_pc[1:0]!=0: state <= HALT, fetch_err <= 1, fpc unchanged.
  - A pop in the same cycle is treated as consumed by decode; the flush still removes all other entries.
- HALT: no pushes; instr_addr holds fpc. Only an aligned redirect leaves HALT; a misaligned redirect keeps HALT.
- Latency:
  - First entry is captured at the first rising edge after rst_n rises; out_valid=1 in the following cycle.
  - After an aligned redirect: one bubble cycle, then the target instruction is valid.
- out_valid = (count!=0). Head outputs are registered FIFO contents; no combinational path from instr to the out_* ports.
- Stall (out_ready=0, FIFO full): fpc and instr_addr hold, FIFO contents hold, out_valid stays 1.
- Throughput: with out_ready held high, one instruction per cycle.

Test Plan:
- Reset, RESET_PC=0, out_ready=1, memory holds word k at address 4k -> out_pc runs 0,4,8,... one per cycle; out_instr=word k; out_pc_plus4=out_pc+4; first out_valid in the second cycle after reset release.
- out_ready=0 for 5 cycles after the first fetch -> count saturates at 2; instr_addr holds at 8; out_pc stays 0. Release out_ready -> 0,4,8 are delivered in order with no loss or duplication.
- redirect_valid=1, redirect_pc=0x40 while FIFO holds 2 entries -> next cycle out_valid=0 and instr_addr=0x40; the cycle after, out_pc=0x40.
- redirect_pc=0x42 -> fetch_err=1, out_valid=0, instr_addr frozen for 10 cycles. Then redirect_pc=0x80 -> fetch_err=0 and the fetch at 0x80 resumes.
- RESET_PC=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc_plus4 of the FFFF_FFFC entry = 0.
- Drop rst_n mid-stream with the FIFO full -> out_valid=0 and instr_addr=RESET_PC immediately, without waiting for a clock edge; normal fetch resumes after release.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, reads instruction memory combinationally and buffers {pc, instr} in a small FIFO.
// One-cycle capture latency to out_valid; fetch stalls while the FIFO is full and not popped; redirect flushes.
module instr_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [ADDR_WIDTH-1:0] out_pc_plus4,
  output logic                  fetch_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {RUN, HALT} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   fpc;
  logic [CNT_W-1:0]        count;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0]   pc_q    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   instr_q [FIFO_DEPTH];
  logic                    push, pop, redirect_aligned;

  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);
  assign pop  = out_valid & out_ready;
  assign push = (state == RUN) & ~redirect_valid &
                ((count < CNT_W'(FIFO_DEPTH)) | pop);

  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = redirect_aligned ? RUN : HALT;
    end
  end

  // Redirect wins over push/pop: a same-cycle pop is simply absorbed by the flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      fpc    <= RESET_PC;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        if (redirect_aligned) begin
          fpc <= redirect_pc;
        end
      end else begin
        count <= count + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          fpc    <= fpc + ADDR_WIDTH'(32'd4);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // Payload storage needs no reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]    <= fpc;
      instr_q[wr_ptr] <= instr;
    end
  end

  assign instr_addr   = fpc;
  assign out_valid    = (count != '0);
  assign out_pc       = pc_q[rd_ptr];
  assign out_instr    = instr_q[rd_ptr];
  assign out_pc_plus4 = out_pc + ADDR_WIDTH'(32'd4);
  assign fetch_err    = (state == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table-driven cycle script, in-order PC scoreboard, random traffic, async reset and PC wrap.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_addr, instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_pc_plus4;
  logic        fetch_err;

  logic        rst2_n = 1'b0;
  logic [31:0] instr_addr2, instr2;
  logic        out_valid2, fetch_err2;
  logic        out_ready2 = 1'b1;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = '0;
  logic [31:0] out_instr2, out_pc2, out_pc_plus42;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) ^ 32'h5A00_0000;
  endfunction

  assign instr  = mem_word(instr_addr);
  assign instr2 = mem_word(instr_addr2);

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .instr_addr(instr_addr), .instr(instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .fetch_err(fetch_err)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .instr_addr(instr_addr2), .instr(instr2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
    .out_pc(out_pc2), .out_pc_plus4(out_pc_plus42), .fetch_err(fetch_err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard of PCs decode should see, in order.
  logic [31:0] exp_q[$];

  task automatic sb_load(input logic [31:0] base);
    exp_q.delete();
    for (int k = 0; k < 256; k++) exp_q.push_back(base + 32'(4 * k));
  endtask

  task automatic sb_step();
    logic [31:0] e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", out_pc, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_instr", out_instr, mem_word(e));
        chk("sb_pc_plus4", out_pc_plus4, e + 32'd4);
      end
    end
  endtask

  task automatic sb_redirect(input logic rv, input logic [31:0] rpc);
    if (rv) begin
      if (rpc[1:0] == 2'b00) sb_load(rpc);
      else exp_q.delete();
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_vld;
    logic [31:0] e_addr;
    logic        e_err;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic vld, input logic [31:0] addr, input logic err,
                     input logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_vld = vld; v.e_addr = addr; v.e_err = err; v.e_pc = pc;
    vt.push_back(v);
  endtask

  initial begin
    logic        halted;
    int          pops;

    // Each row: inputs for the cycle, and the registered outputs seen before its rising edge.
    add(0, 0, 32'h0,  0, 32'h00, 0, 32'h0);
    add(0, 0, 32'h0,  1, 32'h04, 0, 32'h0);
    for (int k = 0; k < 4; k++) add(0, 0, 32'h0, 1, 32'h08, 0, 32'h0);
    add(1, 0, 32'h0,  1, 32'h08, 0, 32'h00);
    add(1, 0, 32'h0,  1, 32'h0C, 0, 32'h04);
    add(1, 1, 32'h40, 1, 32'h10, 0, 32'h08);
    add(1, 0, 32'h0,  0, 32'h40, 0, 32'h00);
    add(1, 0, 32'h0,  1, 32'h44, 0, 32'h40);
    add(1, 1, 32'h42, 1, 32'h48, 0, 32'h44);
    for (int k = 0; k < 10; k++) add(1, 0, 32'h0, 0, 32'h48, 1, 32'h0);
    add(1, 1, 32'h42, 0, 32'h48, 1, 32'h0);
    add(1, 1, 32'h80, 0, 32'h48, 1, 32'h0);
    add(1, 0, 32'h0,  0, 32'h80, 0, 32'h0);
    add(1, 0, 32'h0,  1, 32'h84, 0, 32'h80);
    add(1, 0, 32'h0,  1, 32'h88, 0, 32'h84);

    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_instr_addr", instr_addr, 32'h0);
    chk("reset_fetch_err", 32'(fetch_err), 32'd0);

    rst_n = 1'b1;
    sb_load(32'h0);
    for (int i = 0; i < vt.size(); i++) begin
      out_ready      = vt[i].rdy;
      redirect_valid = vt[i].rv;
      redirect_pc    = vt[i].rpc;
      chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_vld));
      chk($sformatf("row%0d_instr_addr", i), instr_addr, vt[i].e_addr);
      chk($sformatf("row%0d_fetch_err", i), 32'(fetch_err), 32'(vt[i].e_err));
      if (vt[i].e_vld) chk($sformatf("row%0d_out_pc", i), out_pc, vt[i].e_pc);
      sb_step();
      sb_redirect(vt[i].rv, vt[i].rpc);
      @(negedge clk);
    end

    // Random backpressure and redirects.
    redirect_valid = 1'b0;
    halted = 1'b0;
    for (int i = 0; i < 300; i++) begin
      out_ready      = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = {22'd0, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00};
      chk("rand_fetch_err", 32'(fetch_err), 32'(halted));
      sb_step();
      sb_redirect(redirect_valid, redirect_pc);
      if (redirect_valid) halted = (redirect_pc[1:0] != 2'b00);
      @(negedge clk);
    end

    // Fill the FIFO at a known address, then reset asynchronously between edges.
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_instr_addr", instr_addr, 32'h108);
    chk("full_out_pc", out_pc, 32'h100);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_instr_addr", instr_addr, 32'h0);
    chk("async_rst_fetch_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    sb_load(32'h0);
    pops = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) pops++;
      sb_step();
      @(negedge clk);
    end
    chk("post_reset_throughput", 32'(pops), 32'd29);

    // PC wrap at the top of the address space.
    rst2_n = 1'b1;
    chk("wrap_reset_valid", 32'(out_valid2), 32'd0);
    chk("wrap_reset_addr", instr_addr2, 32'hFFFF_FFF8);
    begin
      logic [31:0] wpc[3];
      logic [31:0] wp4[3];
      wpc[0] = 32'hFFFF_FFF8; wpc[1] = 32'hFFFF_FFFC; wpc[2] = 32'h0000_0000;
      wp4[0] = 32'hFFFF_FFFC; wp4[1] = 32'h0000_0000; wp4[2] = 32'h0000_0004;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk($sformatf("wrap%0d_valid", k), 32'(out_valid2), 32'd1);
        chk($sformatf("wrap%0d_pc", k), out_pc2, wpc[k]);
        chk($sformatf("wrap%0d_pc_plus4", k), out_pc_plus42, wp4[k]);
        chk($sformatf("wrap%0d_instr", k), out_instr2, mem_word(wpc[k]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
